// File: rtl/sp_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
package sp_rx_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter that must hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sp_frame_rx_if.sv
// Serial input and decoded parallel output bundle of the frame receiver.
interface sp_frame_rx_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
);

  logic              ena;
  logic              s_in;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              par_err;

  modport master (
    output ena,
    output s_in,
    input  addr_out,
    input  data_out,
    input  valid,
    input  par_err
  );

  modport slave (
    input  ena,
    input  s_in,
    output addr_out,
    output data_out,
    output valid,
    output par_err
  );

endinterface

// File: rtl/sp_shift_reg.sv
// Right-shift register: new bit enters the MSB; clear has priority over shift.
module sp_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] q
);

  if (W > 1) begin : g_wide
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           q <= '0;
      else if (clr)      q <= '0;
      else if (shift_en) q <= {din, q[W-1:1]};
    end
  end else begin : g_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           q <= '0;
      else if (clr)      q <= '0;
      else if (shift_en) q <= din;
    end
  end

endmodule

// File: rtl/sp_frame_rx.sv
// Serial-to-parallel frame receiver: LSB-first shift, split into address/data,
// optional trailing even-parity bit, one-cycle valid strobe, abort on ena low.
module sp_frame_rx
  import sp_rx_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned PARITY_EN = 0
) (
  input logic          clk,
  input logic          rst,
  sp_frame_rx_if.slave bus
);

  localparam int unsigned F      = ADDR_W + DATA_W;
  localparam int unsigned N      = F + PARITY_EN;
  localparam int unsigned CNT_W  = cnt_width(N);
  localparam logic        PAR_ON = (PARITY_EN != 0);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             par_acc, par_acc_d;
  logic             done_c;
  logic [N-1:0]     sr;
  logic [N-1:0]     frame_c;

  sp_shift_reg #(.W(N)) u_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (bus.ena),
    .clr      (~bus.ena),
    .din      (bus.s_in),
    .q        (sr)
  );

  // Completed frame as it will look once the bit on s_in is shifted in.
  assign frame_c = {bus.s_in, sr[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      par_acc <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      par_acc <= par_acc_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    par_acc_d = par_acc;
    done_c    = 1'b0;

    case (state)
      IDLE:    if (bus.ena)  state_d = SHIFT;
      SHIFT:   if (!bus.ena) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every ena=1 edge samples a bit; the last one wraps straight into the next frame.
    if (bus.ena) begin
      if (cnt == CNT_W'(N - 1)) begin
        done_c    = 1'b1;
        cnt_d     = '0;
        par_acc_d = 1'b0;
      end else begin
        cnt_d     = cnt + CNT_W'(1);
        par_acc_d = par_acc ^ bus.s_in;
      end
    end else begin
      cnt_d     = '0;
      par_acc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.addr_out <= '0;
      bus.data_out <= '0;
      bus.valid    <= 1'b0;
      bus.par_err  <= 1'b0;
    end else begin
      bus.valid   <= done_c;
      bus.par_err <= done_c & PAR_ON & (par_acc ^ bus.s_in);
      if (done_c) {bus.addr_out, bus.data_out} <= frame_c[F-1:0];
    end
  end

endmodule

// File: tb/tb_sp_frame_rx.sv
// Directed bench for sp_frame_rx: default, parity-enabled and 6+10 bit instances.
module tb_sp_frame_rx;

  logic clk;
  logic rst;
  logic ena;
  logic s_in;

  int unsigned n_checks;
  int unsigned n_pass;

  sp_frame_rx_if #(.ADDR_W(4), .DATA_W(4))  bus_a ();
  sp_frame_rx_if #(.ADDR_W(4), .DATA_W(4))  bus_b ();
  sp_frame_rx_if #(.ADDR_W(6), .DATA_W(10)) bus_c ();

  assign bus_a.ena  = ena;
  assign bus_a.s_in = s_in;
  assign bus_b.ena  = ena;
  assign bus_b.s_in = s_in;
  assign bus_c.ena  = ena;
  assign bus_c.s_in = s_in;

  sp_frame_rx #(.ADDR_W(4), .DATA_W(4), .PARITY_EN(0)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  sp_frame_rx #(.ADDR_W(4), .DATA_W(4), .PARITY_EN(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );
  sp_frame_rx #(.ADDR_W(6), .DATA_W(10), .PARITY_EN(0)) dut_c (
    .clk (clk), .rst (rst), .bus (bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Apply one cycle of input, return 1 time unit after the sampling edge.
  task automatic tick(input logic e, input logic b);
    ena  = e;
    s_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input int unsigned nbits);
    for (int i = 0; i < int'(nbits); i++) tick(1'b1, v[i]);
  endtask

  initial begin
    logic [15:0] two;
    n_checks = 0;
    n_pass   = 0;
    rst  = 1'b1;
    ena  = 1'b0;
    s_in = 1'b0;
    #12;
    check("rst_addr", 32'(bus_a.addr_out), 32'h0);
    check("rst_data", 32'(bus_a.data_out), 32'h0);
    check("rst_valid", 32'(bus_a.valid), 32'h0);
    check("rst_perr", 32'(bus_b.par_err), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single default frame, bits 1,0,1,0,0,1,0,1
    send(32'hA5, 7);
    check("t1_valid_early", 32'(bus_a.valid), 32'h0);
    tick(1'b1, 1'b1);
    check("t1_valid", 32'(bus_a.valid), 32'h1);
    check("t1_addr", 32'(bus_a.addr_out), 32'hA);
    check("t1_data", 32'(bus_a.data_out), 32'h5);
    check("t1_perr", 32'(bus_a.par_err), 32'h0);
    tick(1'b0, 1'b0);
    check("t1_valid_drop", 32'(bus_a.valid), 32'h0);
    check("t1_addr_hold", 32'(bus_a.addr_out), 32'hA);

    // 2: back-to-back 0xA5 then 0x3C, valid only after ticks 7 and 15
    two = 16'h3CA5;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, two[i]);
      check($sformatf("t2_valid_%0d", i), 32'(bus_a.valid),
            (i == 7 || i == 15) ? 32'h1 : 32'h0);
    end
    check("t2_addr", 32'(bus_a.addr_out), 32'h3);
    check("t2_data", 32'(bus_a.data_out), 32'hC);

    // 3: abort after 5 bits, then full 0x96
    tick(1'b0, 1'b0);
    send(32'h1F, 5);
    check("t3_partial_valid", 32'(bus_a.valid), 32'h0);
    tick(1'b0, 1'b1);
    check("t3_abort_valid", 32'(bus_a.valid), 32'h0);
    check("t3_hold_addr", 32'(bus_a.addr_out), 32'h3);
    check("t3_hold_data", 32'(bus_a.data_out), 32'hC);
    send(32'h96, 7);
    check("t3_valid_early", 32'(bus_a.valid), 32'h0);
    tick(1'b1, 1'b1);
    check("t3_valid", 32'(bus_a.valid), 32'h1);
    check("t3_addr", 32'(bus_a.addr_out), 32'h9);
    check("t3_data", 32'(bus_a.data_out), 32'h6);

    // 4: parity instance, 0xA5 with good then bad parity
    tick(1'b0, 1'b0);
    send(32'h0A5, 8);
    check("t4_valid_8", 32'(bus_b.valid), 32'h0);
    tick(1'b1, 1'b0);
    check("t4_valid_9", 32'(bus_b.valid), 32'h1);
    check("t4_perr_ok", 32'(bus_b.par_err), 32'h0);
    check("t4_addr", 32'(bus_b.addr_out), 32'hA);
    check("t4_data", 32'(bus_b.data_out), 32'h5);
    send(32'h1A5, 9);
    check("t4b_valid", 32'(bus_b.valid), 32'h1);
    check("t4b_perr", 32'(bus_b.par_err), 32'h1);
    check("t4b_addr", 32'(bus_b.addr_out), 32'hA);
    check("t4b_data", 32'(bus_b.data_out), 32'h5);
    tick(1'b0, 1'b0);
    check("t4b_perr_drop", 32'(bus_b.par_err), 32'h0);
    check("t4b_valid_drop", 32'(bus_b.valid), 32'h0);

    // 5: 6+10 bit instance, 16'hBEEF
    send(32'hBEEF, 15);
    check("t5_valid_early", 32'(bus_c.valid), 32'h0);
    tick(1'b1, 1'b1);
    check("t5_valid", 32'(bus_c.valid), 32'h1);
    check("t5_addr", 32'(bus_c.addr_out), 32'h2F);
    check("t5_data", 32'(bus_c.data_out), 32'h2EF);

    // 6: async reset in the middle of bit 4, then frame 0x12
    tick(1'b0, 1'b0);
    send(32'h0F, 4);
    ena  = 1'b1;
    s_in = 1'b1;
    #3;
    rst = 1'b1;
    ena = 1'b0;
    #1;
    check("t6_rst_addr", 32'(bus_a.addr_out), 32'h0);
    check("t6_rst_data", 32'(bus_a.data_out), 32'h0);
    check("t6_rst_addr_c", 32'(bus_c.addr_out), 32'h0);
    check("t6_rst_data_c", 32'(bus_c.data_out), 32'h0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(32'h12, 7);
    check("t6_valid_early", 32'(bus_a.valid), 32'h0);
    tick(1'b1, 1'b0);
    check("t6_valid", 32'(bus_a.valid), 32'h1);
    check("t6_addr", 32'(bus_a.addr_out), 32'h1);
    check("t6_data", 32'(bus_a.data_out), 32'h2);
    check("t6_perr", 32'(bus_a.par_err), 32'h0);
    tick(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
